// File: rtl/gzip_ctrl_regs.sv
// Byte-addressed control/status register bank for the Deflate core: control bytes, status
// snapshot, sticky W1C events with masked irq, and a self-timed soft-reset pulse.
module gzip_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH       = 5,
  parameter int unsigned NUM_CTRL         = 4,
  parameter int unsigned STATUS_BYTES     = 12,
  parameter logic [7:0]  DEVICE_ID        = 8'hB9,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH        = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic                      mem_addr_update,
  input  logic                      w_wren,
  input  logic [7:0]                w_data,
  output logic                      w_full,
  input  logic                      r_rden,
  output logic [7:0]                r_data,
  output logic                      r_empty,
  output logic [NUM_CTRL*8-1:0]     ctrl_out,
  input  logic [STATUS_BYTES*8-1:0] status_in,
  input  logic [7:0]                event_in,
  output logic                      irq,
  output logic                      core_rst
);

  localparam logic [ADDR_WIDTH-1:0] EvAddr   = ADDR_WIDTH'(NUM_CTRL + 1);
  localparam logic [ADDR_WIDTH-1:0] MskAddr  = ADDR_WIDTH'(NUM_CTRL + 2);
  localparam logic [ADDR_WIDTH-1:0] StAddr   = ADDR_WIDTH'(NUM_CTRL + 3);
  localparam logic [ADDR_WIDTH-1:0] RstAddr  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  PulseLen = CNT_WIDTH'(RST_PULSE_CYCLES);

  logic [NUM_CTRL*8-1:0]     ctrl_q, ctrl_d;
  logic [STATUS_BYTES*8-1:0] snap_q;
  logic [7:0]                sticky_q, sticky_d;
  logic [7:0]                mask_q, mask_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [7:0]                r_data_q;
  logic                      irq_q, irq_d;
  logic [7:0]                rd_byte;
  logic                      capture, trigger;

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rd_byte = '0;
    if (mem_addr == '0) rd_byte = DEVICE_ID;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (mem_addr == ADDR_WIDTH'(k + 1)) rd_byte = ctrl_q[8*k +: 8];
    end
    if (mem_addr == EvAddr)  rd_byte = sticky_q;
    if (mem_addr == MskAddr) rd_byte = mask_q;
    for (int k = 0; k < STATUS_BYTES; k++) begin
      if (mem_addr == StAddr + ADDR_WIDTH'(k)) rd_byte = snap_q[8*k +: 8];
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (w_wren && mem_addr == ADDR_WIDTH'(k + 1)) ctrl_d[8*k +: 8] = w_data;
    end
    // Soft-reset trigger bit is self-clearing and never held.
    ctrl_d[7] = 1'b0;

    mask_d = mask_q;
    if (w_wren && mem_addr == MskAddr) mask_d = w_data;

    // Clear first, then OR in new events so a same-cycle set wins.
    sticky_d = sticky_q;
    if (w_wren && mem_addr == EvAddr) sticky_d = sticky_q & ~w_data;
    sticky_d = sticky_d | event_in;

    irq_d = |(sticky_d & mask_d);

    trigger = w_wren && (mem_addr == RstAddr) && w_data[7];
    cnt_d   = cnt_q;
    if (trigger) begin
      cnt_d = PulseLen;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    capture = mem_addr_update && (mem_addr == StAddr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      snap_q   <= '0;
      sticky_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      r_data_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      if (capture) snap_q <= status_in;
      if (r_rden) r_data_q <= rd_byte;
    end
  end

  assign w_full   = 1'b0;
  assign r_empty  = 1'b0;
  assign r_data   = r_data_q;
  assign ctrl_out = ctrl_q;
  assign irq      = irq_q;
  assign core_rst = (cnt_q != '0);

endmodule

// File: tb/tb_gzip_ctrl_regs.sv
// Self-checking bench for gzip_ctrl_regs: read expectations go through a scoreboard queue.
module tb_gzip_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_addr;
  logic        mem_addr_update;
  logic        w_wren;
  logic [7:0]  w_data;
  logic        w_full;
  logic        r_rden;
  logic [7:0]  r_data;
  logic        r_empty;
  logic [31:0] ctrl_out;
  logic [95:0] status_in;
  logic [7:0]  event_in;
  logic        irq;
  logic        core_rst;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  string       tag_q[$];
  logic        rd_seen;
  logic [95:0] snap_model;
  int          hi_cnt;

  gzip_ctrl_regs dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr        (mem_addr),
    .mem_addr_update (mem_addr_update),
    .w_wren          (w_wren),
    .w_data          (w_data),
    .w_full          (w_full),
    .r_rden          (r_rden),
    .r_data          (r_data),
    .r_empty         (r_empty),
    .ctrl_out        (ctrl_out),
    .status_in       (status_in),
    .event_in        (event_in),
    .irq             (irq),
    .core_rst        (core_rst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: a read accepted at a posedge is checked at the following negedge.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= r_rden;
  end

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk(tag_q.pop_front(), {24'd0, r_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    mem_addr = addr;
    w_data   = data;
    w_wren   = 1'b1;
    @(negedge clk);
    w_wren   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [7:0] exp);
    mem_addr = addr;
    r_rden   = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    r_rden   = 1'b0;
  endtask

  // Counts consecutive core_rst-high negedges; optionally re-triggers after 10.
  task automatic count_pulse(input bit retrig, output int n);
    n = 0;
    while (core_rst && n < 100) begin
      n++;
      if (retrig && n == 10) begin
        mem_addr = 5'd1;
        w_data   = 8'h83;
        w_wren   = 1'b1;
      end else begin
        w_wren   = 1'b0;
      end
      @(negedge clk);
    end
    w_wren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_addr_update = 1'b0; w_wren = 1'b0; w_data = '0;
    r_rden = 1'b0; status_in = '0; event_in = '0;
    #22 rst = 1'b0;
    @(negedge clk);

    chk("rst_r_data", {24'd0, r_data}, 32'd0);
    chk("rst_ctrl", ctrl_out, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd0);
    chk("w_full", {31'd0, w_full}, 32'd0);
    chk("r_empty", {31'd0, r_empty}, 32'd0);

    rd("dev_id", 5'd0, 8'hB9);
    wr(5'd2, 8'h5A);
    rd("ctrl2", 5'd2, 8'h5A);
    chk("ctrl_out_b1", {24'd0, ctrl_out[15:8]}, 32'h5A);
    wr(5'd0, 8'hFF);
    rd("dev_id_ro", 5'd0, 8'hB9);
    wr(5'd4, 8'hC3);
    chk("ctrl_out_b3", {24'd0, ctrl_out[31:24]}, 32'hC3);
    rd("unmapped19", 5'd19, 8'h00);
    wr(5'd31, 8'h77);
    rd("unmapped31", 5'd31, 8'h00);

    // Snapshot capture then live status changes underneath it.
    status_in  = 96'h0102_0304_0506_0708_090A_0B0C;
    snap_model = status_in;
    mem_addr = 5'd7; mem_addr_update = 1'b1;
    @(negedge clk);
    mem_addr_update = 1'b0;
    status_in = '1;
    for (int i = 0; i < 12; i++) begin
      rd($sformatf("snap%0d", i), 5'(7 + i), snap_model[8*i +: 8]);
    end
    wr(5'd7, 8'h55);
    rd("snap_ro", 5'd7, 8'h0C);
    mem_addr = 5'd8; mem_addr_update = 1'b1;
    @(negedge clk);
    mem_addr_update = 1'b0;
    rd("no_capture", 5'd7, 8'h0C);
    // Capture coinciding with a read returns the old copy.
    mem_addr = 5'd7; mem_addr_update = 1'b1; r_rden = 1'b1;
    exp_q.push_back(snap_model[7:0]); tag_q.push_back("snap_same_cycle");
    @(negedge clk);
    mem_addr_update = 1'b0; r_rden = 1'b0;
    snap_model = status_in;
    rd("snap_new", 5'd7, snap_model[7:0]);

    // Events, mask, irq.
    event_in = 8'h81;
    @(negedge clk);
    event_in = 8'h00;
    chk("irq_unmasked", {31'd0, irq}, 32'd0);
    wr(5'd6, 8'h01);
    chk("irq_masked", {31'd0, irq}, 32'd1);
    rd("ev_sticky", 5'd5, 8'h81);
    rd("ev_read_noclr", 5'd5, 8'h81);
    event_in = 8'h01;
    wr(5'd5, 8'h01);
    event_in = 8'h00;
    rd("ev_set_wins", 5'd5, 8'h81);
    chk("irq_held", {31'd0, irq}, 32'd1);
    wr(5'd5, 8'h81);
    rd("ev_cleared", 5'd5, 8'h00);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd("mask", 5'd6, 8'h01);

    // Soft reset pulse.
    wr(5'd1, 8'h83);
    count_pulse(1'b0, hi_cnt);
    chk("pulse_len", hi_cnt, 32'd16);
    rd("ctrl1_trig_clr", 5'd1, 8'h03);
    chk("ctrl_out_b0", {24'd0, ctrl_out[7:0]}, 32'h03);
    wr(5'd1, 8'h83);
    count_pulse(1'b1, hi_cnt);
    chk("pulse_retrig", hi_cnt, 32'd26);

    // Asynchronous reset in the middle of a pulse.
    event_in = 8'h01;
    @(negedge clk);
    event_in = 8'h00;
    wr(5'd1, 8'h83);
    rd("pre_rst_read", 5'd2, 8'h5A);
    chk("pre_rst_core", {31'd0, core_rst}, 32'd1);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_core_rst", {31'd0, core_rst}, 32'd0);
    chk("async_ctrl", ctrl_out, 32'd0);
    chk("async_r_data", {24'd0, r_data}, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    rd("post_rst_mask", 5'd6, 8'h00);
    rd("post_rst_ev", 5'd5, 8'h00);
    rd("post_rst_snap", 5'd7, 8'h00);

    @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
